// File: rtl/pcs_apb_cfg_pkg.sv
// ----------------------------------------------------------------------------
// pcs_apb_cfg_pkg
// Shared types for the Base-R core configuration APB initiator: the command
// opcode encoding seen on cmd_op and the initiator's FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package pcs_apb_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_ILL  = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_CHECK,
        ST_GAP,
        ST_RESP
    } state_t;

endpackage

// File: rtl/pcs_apb_cfg_master_if.sv
// ----------------------------------------------------------------------------
// pcs_apb_cfg_master_if
// Bundles the command/response handshake and the APB3 configuration bus of
// pcs_apb_cfg_master.
//   master modport : the initiator's view (commands in, APB driven out)
//   slave  modport : the environment's view (command source + APB responder)
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata/cmd_mask : command channel
//   rsp_valid/rsp_rdata/rsp_err                            : response pulse
//   busy                                                   : initiator not idle
//   core_psel/core_penable/core_pwrite/core_paddr/core_pwdata/core_prdata : APB
// ----------------------------------------------------------------------------
interface pcs_apb_cfg_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    logic              core_psel;
    logic              core_penable;
    logic              core_pwrite;
    logic [ADDR_W-1:0] core_paddr;
    logic [DATA_W-1:0] core_pwdata;
    logic [DATA_W-1:0] core_prdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, core_prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               core_psel, core_penable, core_pwrite, core_paddr, core_pwdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, core_prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               core_psel, core_penable, core_pwrite, core_paddr, core_pwdata
    );
endinterface

// File: rtl/pcs_apb_cfg_master.sv
// ----------------------------------------------------------------------------
// pcs_apb_cfg_master
// APB3 initiator for the Base-R core configuration port. Accepts one command
// at a time (write, read, poll-until-match with timeout), runs it as
// fixed-length APB transfers (no PREADY) and returns one response pulse.
// Ports:
//   i_free_clk : sole clock
//   ext_rst_n  : asynchronous active-low reset, clears every output
//   bus        : pcs_apb_cfg_master_if.master (command, response, APB)
// ----------------------------------------------------------------------------
module pcs_apb_cfg_master
    import pcs_apb_cfg_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 1,
    parameter int POLL_TRIES    = 1024,
    parameter int POLL_GAP      = 16
) (
    input  logic                 i_free_clk,
    input  logic                 ext_rst_n,
    pcs_apb_cfg_master_if.master bus
);

    localparam int ACC_W = $clog2(ACCESS_CYCLES + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int TRY_W = $clog2(POLL_TRIES + 1);

    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCESS_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(POLL_TRIES - 1);

    state_t            state;
    cmd_op_t           op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ACC_W-1:0]  acc_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TRY_W-1:0]  tries;

    // Only the masked bits of the last poll read have to equal the expected value.
    logic poll_hit;
    assign poll_hit = ((rdata_q ^ wdata_q) & mask_q) == '0;

    // NOTE: every output is a flop set alongside the state it belongs to, so
    // each branch assigns the values the *next* state must present.
    // NOTE: sequential state uses non-blocking assignments only; a blocking
    // assignment here would let later statements see half-updated state.
    always_ff @(posedge i_free_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state             <= ST_IDLE;
            op_q              <= OP_WR;
            wdata_q           <= '0;
            mask_q            <= '0;
            rdata_q           <= '0;
            acc_cnt           <= '0;
            gap_cnt           <= '0;
            tries             <= '0;
            // cmd_ready stays low in reset and rises on the first clock after.
            bus.cmd_ready     <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_rdata     <= '0;
            bus.rsp_err       <= 1'b0;
            bus.busy          <= 1'b0;
            bus.core_psel     <= 1'b0;
            bus.core_penable  <= 1'b0;
            bus.core_pwrite   <= 1'b0;
            bus.core_paddr    <= '0;
            bus.core_pwdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= cmd_op_t'(bus.cmd_op);
                        wdata_q       <= bus.cmd_wdata;
                        mask_q        <= bus.cmd_mask;
                        tries         <= '0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (cmd_op_t'(bus.cmd_op) == OP_ILL) begin
                            // Illegal op: answer at once, never touch the APB.
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            // Address/data/direction are loaded once here and
                            // held for every transfer of this command.
                            state            <= ST_SETUP;
                            bus.core_psel    <= 1'b1;
                            bus.core_penable <= 1'b0;
                            bus.core_paddr   <= bus.cmd_addr;
                            bus.core_pwdata  <= bus.cmd_wdata;
                            bus.core_pwrite  <= (cmd_op_t'(bus.cmd_op) == OP_WR);
                        end
                    end
                end

                ST_SETUP: begin
                    state            <= ST_ACCESS;
                    bus.core_penable <= 1'b1;
                    acc_cnt          <= '0;
                end

                ST_ACCESS: begin
                    if (acc_cnt == ACC_LAST) begin
                        bus.core_psel    <= 1'b0;
                        bus.core_penable <= 1'b0;
                        if (op_q != OP_WR) begin
                            rdata_q <= bus.core_prdata;
                        end
                        if (op_q == OP_POLL) begin
                            state <= ST_CHECK;
                        end else begin
                            // rdata_q is loading on this same edge, so the
                            // read response takes the bus value directly.
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= (op_q == OP_RD) ? bus.core_prdata : '0;
                        end
                    end else begin
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end
                end

                ST_CHECK: begin
                    if (poll_hit || tries == TRY_LAST) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= !poll_hit;
                        bus.rsp_rdata <= rdata_q;
                    end else begin
                        state   <= ST_GAP;
                        tries   <= tries + TRY_W'(1);
                        gap_cnt <= '0;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state         <= ST_SETUP;
                        bus.core_psel <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ST_RESP: begin
                    state         <= ST_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcs_apb_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_pcs_apb_cfg_master
// Two initiators share one clock/reset:
//   dut 0 : ACCESS_CYCLES=1, POLL_TRIES=4, POLL_GAP=16
//   dut 1 : ACCESS_CYCLES=3, POLL_TRIES=2, POLL_GAP=2
// An APB responder/monitor returns a per-command table of read values and
// tallies transfers, reads, protocol violations and response pulses. Expected
// responses and latencies come from a command-level model built on the timing
// formulas of the block (latency, number of reads, first matching read).
// ----------------------------------------------------------------------------
module tb_pcs_apb_cfg_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int NDUT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Command side, driven from the stimulus process.
    logic [NDUT-1:0] cmd_valid;
    logic [1:0]      cmd_op    [NDUT];
    logic [15:0]     cmd_addr  [NDUT];
    logic [31:0]     cmd_wdata [NDUT];
    logic [31:0]     cmd_mask  [NDUT];

    // Observed outputs.
    logic [NDUT-1:0] cmd_ready, rsp_valid, rsp_err, busy, psel, penable, pwrite;
    logic [31:0]     rsp_rdata [NDUT];
    logic [15:0]     paddr     [NDUT];
    logic [31:0]     pwdata    [NDUT];

    // Responder, driven from the monitor process only.
    logic [31:0]     prdata    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pcs_apb_cfg_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

        pcs_apb_cfg_master #(
            .ADDR_W        (ADDR_W),
            .DATA_W        (DATA_W),
            .ACCESS_CYCLES (g == 0 ? 1 : 3),
            .POLL_TRIES    (g == 0 ? 4 : 2),
            .POLL_GAP      (g == 0 ? 16 : 2)
        ) dut (
            .i_free_clk (clk),
            .ext_rst_n  (rst_n),
            .bus        (bus)
        );

        assign bus.cmd_valid   = cmd_valid[g];
        assign bus.cmd_op      = cmd_op[g];
        assign bus.cmd_addr    = cmd_addr[g];
        assign bus.cmd_wdata   = cmd_wdata[g];
        assign bus.cmd_mask    = cmd_mask[g];
        assign bus.core_prdata = prdata[g];

        assign cmd_ready[g] = bus.cmd_ready;
        assign rsp_valid[g] = bus.rsp_valid;
        assign rsp_rdata[g] = bus.rsp_rdata;
        assign rsp_err[g]   = bus.rsp_err;
        assign busy[g]      = bus.busy;
        assign psel[g]      = bus.core_psel;
        assign penable[g]   = bus.core_penable;
        assign pwrite[g]    = bus.core_pwrite;
        assign paddr[g]     = bus.core_paddr;
        assign pwdata[g]    = bus.core_pwdata;
    end

    function automatic int ac_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int tries_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction
    function automatic int gap_of(input int d);
        return (d == 0) ? 16 : 2;
    endfunction

    // Values the responder returns for the 1st..8th read of the current command.
    logic [31:0] val_tab [NDUT][8];
    int          base_rd   [NDUT];
    logic [15:0] exp_addr  [NDUT];
    logic [31:0] exp_wdata [NDUT];
    logic        exp_pwrite[NDUT];

    // Monitor tallies (written only by the monitor process).
    int rd_cnt   [NDUT] = '{default: 0};
    int xfer_cnt [NDUT] = '{default: 0};
    int viol     [NDUT] = '{default: 0};
    int rsp_cnt  [NDUT] = '{default: 0};
    int acc_run  [NDUT] = '{default: 0};
    int idle_run [NDUT] = '{default: 0};
    int last_gap [NDUT] = '{default: 0};
    bit prev_set [NDUT] = '{default: 1'b0};

    always @(negedge clk) begin
        int idx;
        for (int d = 0; d < NDUT; d++) begin
            // Present the value for the next read before counting this cycle.
            idx = rd_cnt[d] - base_rd[d];
            if (idx < 0) idx = 0;
            if (idx > 7) idx = 7;
            prdata[d] = val_tab[d][idx];

            if (!rst_n) begin
                acc_run[d]  = 0;
                prev_set[d] = 1'b0;
            end else if (!psel[d]) begin
                if (penable[d]) viol[d]++;
                acc_run[d]  = 0;
                prev_set[d] = 1'b0;
                idle_run[d]++;
            end else begin
                if (paddr[d] !== exp_addr[d] || pwdata[d] !== exp_wdata[d] ||
                    pwrite[d] !== exp_pwrite[d]) viol[d]++;
                if (!penable[d]) begin
                    if (prev_set[d]) viol[d]++;
                    prev_set[d] = 1'b1;
                    last_gap[d] = idle_run[d];
                    idle_run[d] = 0;
                    acc_run[d]  = 0;
                end else begin
                    prev_set[d] = 1'b0;
                    acc_run[d]++;
                    if (acc_run[d] > ac_of(d)) viol[d]++;
                    if (acc_run[d] == ac_of(d)) begin
                        xfer_cnt[d]++;
                        if (!pwrite[d]) rd_cnt[d]++;
                    end
                end
            end
            if (rsp_valid[d]) rsp_cnt[d]++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic outs_or(input int d);
        return cmd_ready[d] | rsp_valid[d] | (|rsp_rdata[d]) | rsp_err[d] | busy[d] |
               psel[d] | penable[d] | pwrite[d] | (|paddr[d]) | (|pwdata[d]);
    endfunction

    // Command-level reference: latency from acceptance edge to rsp_valid cycle,
    // number of transfers/reads, and the response contents.
    task automatic model(input int d, input logic [1:0] op, input logic [31:0] wdata,
                         input logic [31:0] mask, output int lat, output int nxf,
                         output int nrd, output logic [31:0] rdata, output logic err);
        int ac, t, k;
        bit found;
        ac = ac_of(d);
        t  = tries_of(d);
        case (op)
            2'b00: begin lat = 2 + ac; nxf = 1; nrd = 0; rdata = '0; err = 1'b0; end
            2'b01: begin lat = 2 + ac; nxf = 1; nrd = 1; rdata = val_tab[d][0]; err = 1'b0; end
            2'b10: begin
                found = 1'b0;
                k     = t;
                for (int i = 0; i < t; i++) begin
                    if (!found && ((val_tab[d][i] & mask) == (wdata & mask))) begin
                        found = 1'b1;
                        k     = i + 1;
                    end
                end
                nxf   = k;
                nrd   = k;
                rdata = val_tab[d][k-1];
                err   = !found;
                lat   = 1 + k * (2 + ac) + (k - 1) * gap_of(d);
            end
            default: begin lat = 1; nxf = 0; nrd = 0; rdata = '0; err = 1'b1; end
        endcase
    endtask

    task automatic issue(input int d, input logic [1:0] op, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mask, input bit hold);
        int lat, nxf, nrd, cyc, n, x0, v0, r0, q0;
        logic [31:0] erd;
        logic eerr;
        model(d, op, wdata, mask, lat, nxf, nrd, erd, eerr);

        n = 0;
        while (cmd_ready[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, n < 100}, 32'd1);

        exp_addr[d]   = addr;
        exp_wdata[d]  = wdata;
        exp_pwrite[d] = (op == 2'b00);
        base_rd[d]    = rd_cnt[d];
        x0 = xfer_cnt[d];
        v0 = viol[d];
        r0 = rsp_cnt[d];
        q0 = rd_cnt[d];

        cmd_op[d]    = op;
        cmd_addr[d]  = addr;
        cmd_wdata[d] = wdata;
        cmd_mask[d]  = mask;
        cmd_valid[d] = 1'b1;
        @(posedge clk);             // acceptance edge N
        @(negedge clk);             // inside cycle N+1
        cyc = 1;
        if (!hold) cmd_valid[d] = 1'b0;
        check("ready_drop", {31'b0, cmd_ready[d]}, 32'd0);
        check("busy_set", {31'b0, busy[d]}, 32'd1);

        while (rsp_valid[d] !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", cyc, lat);
        check("rsp_rdata", rsp_rdata[d], erd);
        check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, eerr});
        cmd_valid[d] = 1'b0;

        @(negedge clk);
        check("rsp_pulse", {31'b0, rsp_valid[d]}, 32'd0);
        check("ready_back", {31'b0, cmd_ready[d]}, 32'd1);
        check("busy_clear", {31'b0, busy[d]}, 32'd0);
        check("xfers", xfer_cnt[d] - x0, nxf);
        check("reads", rd_cnt[d] - q0, nrd);
        check("apb_protocol", viol[d] - v0, 0);
        check("rsp_count", rsp_cnt[d] - r0, 1);
        if (op == 2'b10 && nxf > 1)
            check("poll_gap", last_gap[d], gap_of(d) + 1);  // CHECK cycle + POLL_GAP
    endtask

    task automatic rand_cmd(input int d);
        logic [1:0]  op;
        logic [31:0] wdata, mask;
        int          sel;
        sel = $urandom_range(0, 9);
        op  = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
        wdata = $urandom;
        case ($urandom_range(0, 3))
            0:       mask = '0;
            1:       mask = 32'd1 << $urandom_range(0, 31);
            default: mask = $urandom;
        endcase
        for (int i = 0; i < 8; i++) val_tab[d][i] = $urandom;
        if ($urandom_range(0, 2) != 0) begin
            int m;
            m = $urandom_range(0, tries_of(d) - 1);
            val_tab[d][m] = (val_tab[d][m] & ~mask) | (wdata & mask);
        end
        issue(d, op, 16'($urandom), wdata, mask, bit'($urandom_range(0, 1)));
    endtask

    initial begin
        int r0;
        cmd_valid = '0;
        for (int d = 0; d < NDUT; d++) begin
            cmd_op[d] = '0; cmd_addr[d] = '0; cmd_wdata[d] = '0; cmd_mask[d] = '0;
            base_rd[d] = 0; exp_addr[d] = '0; exp_wdata[d] = '0; exp_pwrite[d] = 1'b0;
            for (int i = 0; i < 8; i++) val_tab[d][i] = '0;
        end

        // Reset state.
        @(negedge clk);
        check("reset_outs_0", {31'b0, outs_or(0)}, 32'd0);
        check("reset_outs_1", {31'b0, outs_or(1)}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", {31'b0, cmd_ready[0]}, 32'd0);
        @(negedge clk);
        check("ready_after_clk", {31'b0, cmd_ready[0]}, 32'd1);
        check("ready_after_clk_1", {31'b0, cmd_ready[1]}, 32'd1);

        // Directed cases.
        issue(0, 2'b00, 16'h0010, 32'hA5A5_0001, 32'h0, 1'b0);
        val_tab[0][0] = 32'h1234_5678;
        issue(0, 2'b01, 16'h0020, 32'h0, 32'h0, 1'b0);
        val_tab[1][0] = 32'h1234_5678;
        issue(1, 2'b01, 16'h0020, 32'h0, 32'h0, 1'b0);

        val_tab[0][0] = 32'h0; val_tab[0][1] = 32'h2;
        val_tab[0][2] = 32'hFFFF_FFFE; val_tab[0][3] = 32'h1;
        issue(0, 2'b10, 16'h0030, 32'h1, 32'h1, 1'b0);

        val_tab[0][0] = 32'h0; val_tab[0][1] = 32'h2;
        val_tab[0][2] = 32'h4; val_tab[0][3] = 32'h6;
        issue(0, 2'b10, 16'h0034, 32'h1, 32'h1, 1'b0);

        val_tab[0][0] = 32'hDEAD_BEEF;
        issue(0, 2'b10, 16'h0038, 32'h1234_0000, 32'h0, 1'b0);

        issue(0, 2'b11, 16'h0044, 32'h5555_AAAA, 32'h0, 1'b1);
        issue(1, 2'b00, 16'h0048, 32'h0BAD_F00D, 32'h0, 1'b1);

        // Reset in the middle of an ACCESS cycle.
        exp_addr[0] = 16'h0040; exp_wdata[0] = 32'hCAFE_0001; exp_pwrite[0] = 1'b1;
        r0 = rsp_cnt[0];
        cmd_op[0] = 2'b00; cmd_addr[0] = 16'h0040; cmd_wdata[0] = 32'hCAFE_0001;
        cmd_mask[0] = '0; cmd_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("rst_setup_psel", {31'b0, psel[0]}, 32'd1);
        @(negedge clk);
        check("rst_access_penable", {31'b0, penable[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_psel", {31'b0, psel[0]}, 32'd0);
        check("rst_async_penable", {31'b0, penable[0]}, 32'd0);
        check("rst_async_outs", {31'b0, outs_or(0)}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_rsp", rsp_cnt[0] - r0, 0);
        issue(0, 2'b00, 16'h0050, 32'h0000_FFFF, 32'h0, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 25; i++) rand_cmd(0);
        for (int i = 0; i < 15; i++) rand_cmd(1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
